// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase scheduler for one intersection shared by NUM_APP approaches.
// It grants green to one approach at a time. Each phase runs
// GREEN -> YELLOW -> ALLRED with min/max green, a fixed yellow time and a fixed
// all-red clearance time. An emergency preempt can steer the next grant.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        synchronous active-low reset
//   req_i         per-approach sensor request (level or pulse)
//   preempt_i     emergency preempt active
//   preempt_id_i  approach to serve under preempt (ignored if >= NUM_APP)
//   green_o       one-hot or zero green lamps (registered)
//   yellow_o      one-hot or zero yellow lamps (registered)
//   red_o         ~(green_o | yellow_o) (registered)
//   active_id_o   approach currently green or yellow
//   pending_o     latched unserved requests
module intersection_phase_scheduler #(
  parameter int unsigned NUM_APP   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_APP-1:0] req_i,
  input  logic               preempt_i,
  input  logic [ID_W-1:0]    preempt_id_i,
  output logic [NUM_APP-1:0] green_o,
  output logic [NUM_APP-1:0] yellow_o,
  output logic [NUM_APP-1:0] red_o,
  output logic [ID_W-1:0]    active_id_o,
  output logic [NUM_APP-1:0] pending_o
);

  localparam logic [CNT_W-1:0] MinGLast = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxGLast = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YelLast  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ArLast   = CNT_W'(ALLRED_T - 1);

  typedef enum logic [1:0] {StIdle, StGreen, StYellow, StAllRed} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    active_q, active_d;
  logic [NUM_APP-1:0] pending_q, pending_d;
  logic [NUM_APP-1:0] green_q, green_d;
  logic [NUM_APP-1:0] yellow_q, yellow_d;
  logic [NUM_APP-1:0] red_q, red_d;

  logic               pre_valid;
  logic [NUM_APP-1:0] cand;
  logic [NUM_APP-1:0] active_oh;
  logic [NUM_APP-1:0] others;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               grant;
  int unsigned        idx;

  assign pre_valid = preempt_i && (32'(preempt_id_i) < NUM_APP);
  assign active_oh = NUM_APP'(1) << active_q;
  assign others    = pending_q & ~active_oh;

  // Winner selection: preempt target, else first candidate after last_q with wrap.
  // Scanning from the far end keeps the closest hit as the final assignment.
  always_comb begin
    cand      = pending_q | req_i;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (pre_valid) begin
      win_found = 1'b1;
      win_id    = preempt_id_i;
    end else begin
      for (int k = int'(NUM_APP); k >= 1; k--) begin
        idx = (int'(last_q) + k) % NUM_APP;
        if (cand[idx]) begin
          win_found = 1'b1;
          win_id    = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    active_d  = active_q;
    green_d   = '0;
    yellow_d  = '0;
    pending_d = pending_q | req_i;
    grant     = 1'b0;

    unique case (state_q)
      StIdle: grant = 1'b1;
      StGreen: begin
        // The served approach's own sensor must not queue a repeat visit.
        pending_d = pending_q | (req_i & ~active_oh);
        green_d   = active_oh;
        if (pre_valid && (preempt_id_i == active_q)) begin
          // Hold green with a frozen timer.
        end else if (pre_valid ||
                     ((others != '0) &&
                      (((timer_q >= MinGLast) && !req_i[active_q]) || (timer_q == MaxGLast)))) begin
          state_d  = StYellow;
          timer_d  = '0;
          green_d  = '0;
          yellow_d = active_oh;
        end else if (timer_q != MaxGLast) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StYellow: begin
        yellow_d = active_oh;
        if (timer_q == YelLast) begin
          state_d  = StAllRed;
          timer_d  = '0;
          yellow_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StAllRed: begin
        if (timer_q == ArLast) begin
          grant = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      timer_d = '0;
      if (win_found) begin
        state_d           = StGreen;
        green_d           = NUM_APP'(1) << win_id;
        active_d          = win_id;
        last_d            = win_id;
        pending_d[win_id] = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end

    red_d = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      last_q    <= ID_W'(NUM_APP - 1);
      active_q  <= '0;
      pending_q <= '0;
      green_q   <= '0;
      yellow_q  <= '0;
      red_q     <= '1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
    end
  end

  assign green_o     = green_q;
  assign yellow_o    = yellow_q;
  assign red_o       = red_q;
  assign active_id_o = active_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed testbench for intersection_phase_scheduler with default parameters
// (4 approaches, min green 5, max green 20, yellow 3, all-red 1).
module tb_intersection_phase_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_id;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] active_id;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;

  intersection_phase_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .preempt_i    (preempt),
    .preempt_id_i (preempt_id),
    .green_o      (green),
    .yellow_o     (yellow),
    .red_o        (red),
    .active_id_o  (active_id),
    .pending_o    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles where the chosen lamp vector equals pat (bounded).
  task automatic count_lamp(input int sel, input logic [3:0] pat, output int n);
    logic [3:0] cur;
    n = 0;
    while (n < 64) begin
      cur = (sel == 0) ? green : ((sel == 1) ? yellow : red);
      if (cur !== pat) break;
      n++;
      step();
    end
  endtask

  // Step until green equals g, bounded to 40 cycles.
  task automatic wait_green(input logic [3:0] g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (green === g) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; preempt = 1'b1; preempt_id = 2'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (red !== 4'b1111 || green !== 4'b0000 || yellow !== 4'b0000 ||
          pending !== 4'b0000 || active_id !== 2'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: red=%b green=%b yellow=%b pend=%b id=%0d want 1111/0000/0000/0000/0",
                 i, red, green, yellow, pending, active_id);
      end
    end
    rst_n = 1'b1; req = 4'b0000; preempt = 1'b0;
  endtask

  task automatic test_idle_grant_rest();
    int bad;
    req = 4'b0010;
    step();
    req = 4'b0000;
    checks++;
    if (green !== 4'b0010 || pending !== 4'b0000 || active_id !== 2'd1) begin
      errors++;
      $display("FAIL idle_grant: green=%b pend=%b id=%0d want 0010/0000/1", green, pending, active_id);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (green !== 4'b0010 || yellow !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL green_rest: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_gap_out();
    bit ok;
    int n;
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_green(4'b0001, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_reach_g0: green=%b want 0001", green);
    end
    step();             // green cycle 1
    req = 4'b0100;
    step();             // green cycle 2
    req = 4'b0000;
    count_lamp(0, 4'b0001, n);
    checks++;
    if (n + 2 != 5) begin
      errors++;
      $display("FAIL gap_green_len: got %0d want 5", n + 2);
    end
    count_lamp(1, 4'b0001, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL gap_yellow_len: got %0d want 3", n);
    end
    count_lamp(2, 4'b1111, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL gap_allred_len: got %0d want 1", n);
    end
    checks++;
    if (green !== 4'b0100 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL gap_next_grant: green=%b pend=%b want 0100/0000", green, pending);
    end
  endtask

  task automatic test_max_out();
    bit ok;
    int n;
    req = 4'b0001;
    wait_green(4'b0001, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL max_reach_g0: green=%b want 0001", green);
    end
    req = 4'b1001;
    step();             // green cycle 1
    req = 4'b0001;
    checks++;
    if (pending !== 4'b1000) begin
      errors++;
      $display("FAIL max_pending: got %b want 1000", pending);
    end
    count_lamp(0, 4'b0001, n);
    req = 4'b0000;
    checks++;
    if (n + 1 != 20) begin
      errors++;
      $display("FAIL max_green_len: got %0d want 20", n + 1);
    end
    checks++;
    if (yellow !== 4'b0001 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL max_yellow: yellow=%b pend=%b want 0001/1000", yellow, pending);
    end
    count_lamp(1, 4'b0001, n);
    count_lamp(2, 4'b1111, n);
    checks++;
    if (green !== 4'b1000 || pending !== 4'b0000 || active_id !== 2'd3) begin
      errors++;
      $display("FAIL max_grant3: green=%b pend=%b id=%0d want 1000/0000/3", green, pending, active_id);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int n;
    logic [1:0] ord [3];
    logic [3:0] pat;
    ord[0] = 2'd1; ord[1] = 2'd3; ord[2] = 2'd0;
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_green(4'b0001, ok);    // green0 now, last served = 0
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_reach_g0: green=%b want 0001", green);
    end
    req = 4'b1011;              // own bit masked during its green
    step();
    req = 4'b0000;
    checks++;
    if (pending !== 4'b1010) begin
      errors++;
      $display("FAIL rr_pending_mask: got %b want 1010", pending);
    end
    count_lamp(0, 4'b0001, n);
    req = 4'b0001;              // re-queue approach 0 during its yellow
    step();
    req = 4'b0000;
    count_lamp(1, 4'b0001, n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL rr_yellow0_rest: got %0d want 2", n);
    end
    for (int i = 0; i < 3; i++) begin
      count_lamp(2, 4'b1111, n);
      checks++;
      if (n != 1) begin
        errors++;
        $display("FAIL rr_allred_%0d: got %0d want 1", i, n);
      end
      pat = 4'b0001 << ord[i];
      checks++;
      if (green !== pat || active_id !== ord[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d: green=%b id=%0d want %b/%0d", i, green, active_id, pat, ord[i]);
      end
      if (i < 2) begin
        count_lamp(0, pat, n);
        checks++;
        if (n != 5) begin
          errors++;
          $display("FAIL rr_green_len_%0d: got %0d want 5", i, n);
        end
        count_lamp(1, pat, n);
        checks++;
        if (n != 3) begin
          errors++;
          $display("FAIL rr_yellow_len_%0d: got %0d want 3", i, n);
        end
      end
    end
  endtask

  task automatic test_preempt();
    int n;
    int bad;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'b0001;
    step();                     // green0 cycle 0
    req = 4'b0000;
    step();                     // green0 cycle 1
    preempt = 1'b1; preempt_id = 2'd2;
    step();
    checks++;
    if (yellow !== 4'b0001 || green !== 4'b0000) begin
      errors++;
      $display("FAIL pre_cut_green: yellow=%b green=%b want 0001/0000", yellow, green);
    end
    count_lamp(1, 4'b0001, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL pre_yellow_len: got %0d want 3", n);
    end
    count_lamp(2, 4'b1111, n);
    checks++;
    if (n != 1 || green !== 4'b0100) begin
      errors++;
      $display("FAIL pre_grant2: allred=%0d green=%b want 1/0100", n, green);
    end
    req = 4'b0001;
    step();
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (green !== 4'b0100) bad++;
      step();
    end
    checks++;
    if (bad != 0 || pending !== 4'b0001) begin
      errors++;
      $display("FAIL pre_hold: bad=%0d pend=%b want 0/0001", bad, pending);
    end
    preempt = 1'b0;             // timer was frozen at 0
    count_lamp(0, 4'b0100, n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL pre_release_len: got %0d want 5", n);
    end
    checks++;
    if (yellow !== 4'b0100) begin
      errors++;
      $display("FAIL pre_release_yellow: got %b want 0100", yellow);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (red !== 4'b1111 || yellow !== 4'b0000 || green !== 4'b0000 ||
        pending !== 4'b0000 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_in_yellow: red=%b yellow=%b green=%b pend=%b id=%0d want 1111/0000/0000/0000/0",
               red, yellow, green, pending, active_id);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (green !== 4'b0000 || red !== 4'b1111) begin
      errors++;
      $display("FAIL idle_after_reset: green=%b red=%b want 0000/1111", green, red);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; preempt = 1'b0; preempt_id = '0;
    #2;
    test_reset();
    test_idle_grant_rest();
    test_gap_out();
    test_max_out();
    test_round_robin();
    test_preempt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Schedules one shared intersection between NUM_APP approaches. Each approach has a vehicle sensor request.
- Grants green to one approach at a time in round-robin order, with min/max green, yellow and all-red clearance timing.
- Supports an emergency preempt override.
- Sits above the per-approach lamp drivers and generalises the two-road Sa/Sb controller to N approaches.

Parameters:
- NUM_APP, 4, number of approaches (2..8)
- ID_W, 2, width of approach index, clog2(NUM_APP)
- MIN_GREEN, 5, minimum green cycles
- MAX_GREEN, 20, maximum green cycles while others wait
- YELLOW_T, 3, yellow cycles
- ALLRED_T, 1, all-red clearance cycles
- CNT_W, 8, phase timer width; must hold MAX_GREEN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset=0 resets on the clk edge)
- req  in  NUM_APP  sensor request per approach, level or pulse
- preempt  in  1  emergency preempt active
- preempt_id  in  ID_W  approach to be served under preempt
- green  out  NUM_APP  one-hot or zero green lamps
- yellow  out  NUM_APP  one-hot or zero yellow lamps
- red  out  NUM_APP  ~(green|yellow)
- active_id  out  ID_W  approach currently green or yellow
- pending  out  NUM_APP  latched unserved requests

Behaviour:
- All outputs are registered. At most one bit of green|yellow is set in any cycle.
- Reset (reset=0 at an edge, from any state, including mid-phase):
  - state=IDLE
  - green=0, yellow=0, red=all ones
  - pending=0, active_id=0, timer=0
  - last_served=NUM_APP-1, so approach 0 has first priority
- States: IDLE (all red), GREEN, YELLOW, ALLRED.
- Request latch:
  - pending[i] sets on any edge where req[i]=1.
  - pending[i] clears on the edge that grants green to i.
  - req[active_id] during its own GREEN does not set pending.
- Arbitration runs in IDLE every cycle, and at the last ALLRED cycle. It uses (pending|req):
  - If preempt=1, the winner is preempt_id.
  - Otherwise the winner is the first set bit scanning from (last_served+1) mod NUM_APP upward with wrap.
  - Winner found: next state GREEN, green[winner]=1, active_id=winner, last_served=winner, timer=0.
  - No winner: IDLE.
- Latency: req[i] high at edge k while IDLE makes green[i] visible after edge k (one cycle).
- GREEN:
  - timer increments each cycle; timer saturates at MAX_GREEN-1.
  - others = pending excluding active_id.
  - Go to YELLOW when others≠0 and either of:
    - timer≥MIN_GREEN-1 and req[active_id]=0 (gap-out)
    - timer==MAX_GREEN-1 (max-out)
  - others=0: rest in green indefinitely.
  - Exact green length on gap-out: max(MIN_GREEN, cycles until a competitor is pending).
- YELLOW: exactly YELLOW_T cycles, then ALLRED.
- ALLRED: exactly ALLRED_T cycles with all red, then arbitrate. The same approach may win again if it is the only one pending.
- Preempt:
  - In GREEN of preempt_id: hold green and freeze the timer while preempt=1.
  - In GREEN of another approach: go to YELLOW on the next edge, ignoring MIN_GREEN.
  - In YELLOW or ALLRED: the phase completes normally, then preempt_id wins arbitration.
  - When preempt drops: normal rules resume with the current timer value.
  - preempt_id ≥ NUM_APP: preempt is ignored.
- Simultaneous events:
  - req[j] on the same edge as the last ALLRED cycle is included in that arbitration.
  - reset=0 overrides everything else.

Test Plan:
1. reset=0 for 2 cycles, with req=4'b1111 and preempt=1 -> red=4'b1111, green=0, yellow=0, pending=0, active_id=0 throughout.
2. From IDLE, pulse req=4'b0010 for one cycle -> green=4'b0010 on the next edge, pending=0; with no further requests green holds for 50 cycles.
3. green[0] active, req[0]=0, pulse req[2] at green cycle 1 -> green[0] lasts 5 cycles, then yellow[0] for 3, all-red for 1, then green=4'b0100.
4. green[0] with req[0] held high and req[3] pulsed at cycle 0 -> green[0] lasts exactly 20 cycles, then yellow[0]; pending=4'b1000 until green[3].
5. IDLE with last_served=0 and req=4'b1011 on one edge -> service order 1, 3, 0, each with the full yellow/all-red sequence between grants.
6. Preempt:
   - preempt=1, preempt_id=2 at green[0] cycle 1 -> yellow[0] on the next edge, then all-red for 1 cycle, then green[2] held for as long as preempt=1.
   - Separately, drive reset=0 during yellow -> all red on the next edge.
